// File: rtl/demultiplexor_loader.sv
// Write-side bank loader: steers data words into ten holding registers either by
// explicit address (IDLE) or by a sequential valid/ready fill (LOAD -> DONE).
module demultiplexor_loader #(
  parameter int unsigned SELECTION = 4,
  parameter int unsigned DATAWIDTH = 9
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_InLow,
  input  logic [DATAWIDTH-1:0] sDataInDemux,
  input  logic [SELECTION-1:0] sSelDemux,
  input  logic                 sWriteDemux,
  input  logic                 sAutoLoadDemux,
  input  logic                 sValidDemux,
  output logic                 sReadyDemux,
  output logic                 sBusyDemux,
  output logic                 sDoneDemux,
  output logic                 sErrDemux,
  output logic [DATAWIDTH-1:0] sDataOutDemux1,
  output logic [DATAWIDTH-1:0] sDataOutDemux2,
  output logic [DATAWIDTH-1:0] sDataOutDemux3,
  output logic [DATAWIDTH-1:0] sDataOutDemux4,
  output logic [DATAWIDTH-1:0] sDataOutDemux5,
  output logic [DATAWIDTH-1:0] sDataOutDemux6,
  output logic [DATAWIDTH-1:0] sDataOutDemux7,
  output logic [DATAWIDTH-1:0] sDataOutDemux8,
  output logic [DATAWIDTH-1:0] sDataOutDemux9,
  output logic [DATAWIDTH-1:0] sDataOutDemux10
);

  localparam int unsigned NumChannels = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic [SELECTION-1:0] sCount;
  logic [SELECTION-1:0] countNext;
  logic                 wrEn;
  logic [SELECTION-1:0] wrAddr;
  logic                 errNext;
  logic [DATAWIDTH-1:0] bank [1:NumChannels];

  // State, counter and error pulse registers
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state     <= IDLE;
      sCount    <= '0;
      sErrDemux <= 1'b0;
    end else begin
      state     <= stateNext;
      sCount    <= countNext;
      sErrDemux <= errNext;
    end
  end

  // Next-state, counter and write-port decode
  always_comb begin
    stateNext = state;
    countNext = sCount;
    wrEn      = 1'b0;
    wrAddr    = sCount;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (sAutoLoadDemux) begin
          countNext = SELECTION'(1);
          stateNext = LOAD;
        end else if (sWriteDemux) begin
          if ((sSelDemux >= SELECTION'(1)) && (sSelDemux <= SELECTION'(NumChannels))) begin
            wrEn   = 1'b1;
            wrAddr = sSelDemux;
          end else begin
            errNext = 1'b1;
          end
        end
      end
      LOAD: begin
        if (sValidDemux) begin
          wrEn   = 1'b1;
          wrAddr = sCount;
          if (sCount == SELECTION'(NumChannels)) begin
            stateNext = DONE;
          end else begin
            countNext = sCount + SELECTION'(1);
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Holding registers; only the addressed channel loads
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      for (int k = 1; k <= NumChannels; k++) begin
        bank[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= NumChannels; k++) begin
        if (wrEn && (wrAddr == SELECTION'(k))) begin
          bank[k] <= sDataInDemux;
        end
      end
    end
  end

  assign sReadyDemux = (state == LOAD);
  assign sBusyDemux  = (state == LOAD) || (state == DONE);
  assign sDoneDemux  = (state == DONE);

  assign sDataOutDemux1  = bank[1];
  assign sDataOutDemux2  = bank[2];
  assign sDataOutDemux3  = bank[3];
  assign sDataOutDemux4  = bank[4];
  assign sDataOutDemux5  = bank[5];
  assign sDataOutDemux6  = bank[6];
  assign sDataOutDemux7  = bank[7];
  assign sDataOutDemux8  = bank[8];
  assign sDataOutDemux9  = bank[9];
  assign sDataOutDemux10 = bank[10];

endmodule

// File: tb/tb_demultiplexor_loader.sv
// Directed bench for demultiplexor_loader: addressed writes, invalid codes,
// continuous and stalled fills, and asynchronous reset mid-fill.
module tb_demultiplexor_loader;

  localparam int unsigned SEL = 4;
  localparam int unsigned DW  = 9;

  logic          clk;
  logic          rstN;
  logic [DW-1:0] dataIn;
  logic [SEL-1:0] sel;
  logic          wr;
  logic          autoLoad;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] outs [1:10];
  logic [DW-1:0] expBank [1:10];

  int nChecks = 0;
  int nFails  = 0;

  demultiplexor_loader #(.SELECTION(SEL), .DATAWIDTH(DW)) dut (
    .CLOCK_50        (clk),
    .RESET_InLow     (rstN),
    .sDataInDemux    (dataIn),
    .sSelDemux       (sel),
    .sWriteDemux     (wr),
    .sAutoLoadDemux  (autoLoad),
    .sValidDemux     (valid),
    .sReadyDemux     (ready),
    .sBusyDemux      (busy),
    .sDoneDemux      (done),
    .sErrDemux       (err),
    .sDataOutDemux1  (outs[1]),
    .sDataOutDemux2  (outs[2]),
    .sDataOutDemux3  (outs[3]),
    .sDataOutDemux4  (outs[4]),
    .sDataOutDemux5  (outs[5]),
    .sDataOutDemux6  (outs[6]),
    .sDataOutDemux7  (outs[7]),
    .sDataOutDemux8  (outs[8]),
    .sDataOutDemux9  (outs[9]),
    .sDataOutDemux10 (outs[10])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic r, input logic b, input logic d, input logic e);
    check({tag, ".ready"}, DW'(ready), DW'(r));
    check({tag, ".busy"},  DW'(busy),  DW'(b));
    check({tag, ".done"},  DW'(done),  DW'(d));
    check({tag, ".err"},   DW'(err),   DW'(e));
  endtask

  task automatic checkBank(input string tag);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("%s.out%0d", tag, k), outs[k], expBank[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; dataIn = '0; sel = '0; wr = 1'b0; autoLoad = 1'b0; valid = 1'b0;
    for (int k = 1; k <= 10; k++) expBank[k] = '0;
    #23;
    checkFlags("inReset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkBank("inReset");
    rstN = 1'b1;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      step();
      checkFlags($sformatf("idle%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkBank("idle");

    // Addressed writes on consecutive cycles
    wr = 1'b1; sel = 4'd1; dataIn = 9'h1A5;
    step();
    expBank[1] = 9'h1A5;
    check("addr1.out1", outs[1], 9'h1A5);
    sel = 4'd10; dataIn = 9'h0F3;
    step();
    wr = 1'b0;
    expBank[10] = 9'h0F3;
    checkFlags("addr10", 1'b0, 1'b0, 1'b0, 1'b0);
    checkBank("addr");

    // Invalid codes: 0, 15, 11
    wr = 1'b1; sel = 4'd0; dataIn = 9'h155;
    step();
    wr = 1'b0;
    checkFlags("inv0", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("inv0.errDrop", DW'(err), DW'(1'b0));
    wr = 1'b1; sel = 4'd15;
    step();
    wr = 1'b0;
    checkFlags("inv15", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("inv15.errDrop", DW'(err), DW'(1'b0));
    wr = 1'b1; sel = 4'd11;
    step();
    wr = 1'b0;
    check("inv11.err", DW'(err), DW'(1'b1));
    step();
    checkBank("inv");

    // Continuous fill
    autoLoad = 1'b1;
    step();
    autoLoad = 1'b0;
    checkFlags("fill.e0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      valid = 1'b1; dataIn = DW'(i);
      step();
      expBank[i] = DW'(i);
      if (i < 10) checkFlags($sformatf("fill.e%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      else        checkFlags("fill.e10", 1'b0, 1'b1, 1'b1, 1'b0);
    end
    valid = 1'b0;
    step();
    checkFlags("fill.e11", 1'b0, 1'b0, 1'b0, 1'b0);
    checkBank("fill");

    // Stalled fill with addressed-write attempts during stalls
    autoLoad = 1'b1;
    step();
    autoLoad = 1'b0;
    for (int w = 1; w <= 10; w++) begin
      valid = 1'b1; wr = 1'b0; dataIn = DW'(9'h100 + w);
      step();
      expBank[w] = DW'(9'h100 + w);
      if (w < 10) begin
        check($sformatf("stall.w%0d.done", w), DW'(done), DW'(1'b0));
        valid = 1'b0; wr = 1'b1; sel = 4'd3; dataIn = 9'h0AA;
        step();
        checkFlags($sformatf("stall.w%0d.a", w), 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkFlags($sformatf("stall.w%0d.b", w), 1'b1, 1'b1, 1'b0, 1'b0);
      end
    end
    valid = 1'b0; wr = 1'b0;
    check("stall.done", DW'(done), DW'(1'b1));
    step();
    checkFlags("stall.end", 1'b0, 1'b0, 1'b0, 1'b0);
    checkBank("stall");

    // Reset after word 4 of a fill
    autoLoad = 1'b1;
    step();
    autoLoad = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      valid = 1'b1; dataIn = DW'(9'h040 + w);
      step();
    end
    valid = 1'b0;
    check("mid.out4", outs[4], 9'h044);
    #2 rstN = 1'b0;
    #1;
    for (int k = 1; k <= 10; k++) expBank[k] = '0;
    checkFlags("midRst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkBank("midRst");
    #2 rstN = 1'b1;
    step();
    checkFlags("postRst", 1'b0, 1'b0, 1'b0, 1'b0);
    wr = 1'b1; sel = 4'd5; dataIn = 9'h1C7;
    step();
    wr = 1'b0;
    expBank[5] = 9'h1C7;
    checkFlags("postRst.wr", 1'b0, 1'b0, 1'b0, 1'b0);
    checkBank("postRst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
